// File: rtl/fir_out_decim.sv
// FIR output stage: decimate, round-shift, saturate to OUT_W,
// then queue results in a show-ahead FIFO behind valid/ready.
module fir_out_decim #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 6,
  parameter int DECIM = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       clr_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       sat_flag,
  output logic                       ovf_flag
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RNDI = 1 << (SHIFT - 1);
  localparam int MAXI = (1 << (OUT_W - 1)) - 1;
  localparam int MINI = -(1 << (OUT_W - 1));
  localparam logic signed [IN_W:0] RND  = (IN_W+1)'(RNDI);
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(MAXI);
  localparam logic signed [IN_W:0] MINV = (IN_W+1)'(MINI);
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
  localparam logic [LW-1:0] FULL_LV = LW'(DEPTH);

  logic [PW-1:0]    phase_q, phase_d;
  logic             pipe_valid_q, pipe_valid_d;
  logic [OUT_W-1:0] pipe_data_q, pipe_data_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] mem_q [DEPTH];

  logic                keep;
  logic signed [IN_W:0] ext_s;
  logic signed [IN_W:0] sum_s;
  logic signed [IN_W:0] shr_s;
  logic                sat_hi;
  logic                sat_lo;
  logic [OUT_W-1:0]    res;
  logic                full;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic                drop;

  // Keep the sample arriving on phase 0 of each DECIM-long group.
  assign keep = in_valid && (phase_q == '0);

  always_comb begin
    phase_d = phase_q;
    if (in_valid) begin
      if (phase_q == PH_LAST) phase_d = '0;
      else                    phase_d = phase_q + 1'b1;
    end
  end

  // Round half up: add half an LSB, then floor-shift.
  assign ext_s = {in_data[IN_W-1], in_data};
  assign sum_s = ext_s + RND;
  assign shr_s = sum_s >>> SHIFT;
  assign sat_hi = shr_s > MAXV;
  assign sat_lo = shr_s < MINV;

  always_comb begin
    res = shr_s[OUT_W-1:0];
    if (sat_hi)      res = MAXV[OUT_W-1:0];
    else if (sat_lo) res = MINV[OUT_W-1:0];
  end

  assign pipe_valid_d = keep;
  assign pipe_data_d  = keep ? res : pipe_data_q;

  assign full  = (level_q == FULL_LV);
  assign push  = pipe_valid_q;
  assign pop   = out_valid && out_ready;
  // A full FIFO still accepts a write when a pop frees the slot.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign wr_d = wr_en ? wr_q + 1'b1 : wr_q;
  assign rd_d = pop ? rd_q + 1'b1 : rd_q;

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  assign sat_d = (keep && (sat_hi || sat_lo)) || (sat_q && !clr_flags);
  assign ovf_d = drop || (ovf_q && !clr_flags);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= '0;
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      sat_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      level_q      <= level_d;
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= pipe_data_q;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_q] : '0;
  assign fifo_level = level_q;
  assign sat_flag   = sat_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_fir_out_decim.sv
// Directed bench for fir_out_decim: instance a uses DECIM=2,
// instance b uses DECIM=1; both share clock and reset.
module tb_fir_out_decim;

  logic clk;
  logic rst;

  logic        a_in_valid, a_clr, a_out_ready;
  logic [15:0] a_in_data;
  logic        a_out_valid, a_sat, a_ovf;
  logic [7:0]  a_out_data;
  logic [2:0]  a_level;

  logic        b_in_valid, b_clr, b_out_ready;
  logic [15:0] b_in_data;
  logic        b_out_valid, b_sat, b_ovf;
  logic [7:0]  b_out_data;
  logic [2:0]  b_level;

  int n_tests;
  int n_fail;

  logic signed [7:0] qa[$];
  logic signed [7:0] qb[$];

  fir_out_decim #(.DECIM(2)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_data(a_in_data),
    .clr_flags(a_clr),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .fifo_level(a_level),
    .sat_flag(a_sat), .ovf_flag(a_ovf)
  );

  fir_out_decim #(.DECIM(1)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_data(b_in_data),
    .clr_flags(b_clr),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .fifo_level(b_level),
    .sat_flag(b_sat), .ovf_flag(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each accepted output; inputs change only just after posedge.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) qa.push_back(a_out_data);
    if (!rst && b_out_valid && b_out_ready) qb.push_back(b_out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_clr = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_clr = 0; b_out_ready = 0;
    tick(); tick();
    n_tests++;
    if (a_out_valid !== 1'b0 || a_level !== 3'd0 || a_out_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_a: got v=%0b lvl=%0d d=%0d want 0,0,0",
               a_out_valid, a_level, a_out_data);
    end
    n_tests++;
    if (a_sat !== 1'b0 || a_ovf !== 1'b0 || b_sat !== 1'b0 || b_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %0b%0b%0b%0b want 0000",
               a_sat, a_ovf, b_sat, b_ovf);
    end
    n_tests++;
    if (b_out_valid !== 1'b0 || b_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_b: got v=%0b lvl=%0d want 0,0", b_out_valid, b_level);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_decim();
    qa.delete();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    a_in_data = 16'd64;
    tick();
    n_tests++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL decim_lat0: got out_valid=%0b want 0", a_out_valid);
    end
    a_in_data = 16'd128;
    tick();
    n_tests++;
    if (a_out_valid !== 1'b1 || $signed(a_out_data) !== 8'sd1) begin
      n_fail++;
      $display("FAIL decim_lat1: got v=%0b d=%0d want 1,1",
               a_out_valid, $signed(a_out_data));
    end
    a_in_data = 16'd192;
    tick();
    a_in_data = 16'd256;
    tick();
    a_in_valid = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (qa.size() != 2 || qa[0] !== 8'sd1 || qa[1] !== 8'sd3) begin
      n_fail++;
      $display("FAIL decim_seq: got n=%0d [%0d,%0d] want n=2 [1,3]",
               qa.size(), qa.size() > 0 ? qa[0] : 8'sd0,
               qa.size() > 1 ? qa[1] : 8'sd0);
    end
  endtask

  task automatic test_rounding();
    logic signed [15:0] din [5];
    logic signed [7:0]  exp [5];
    din = '{16'sd31, 16'sd32, -16'sd32, -16'sd33, -16'sd96};
    exp = '{8'sd0, 8'sd1, 8'sd0, -8'sd1, -8'sd1};
    qb.delete();
    b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1;
      b_in_data = din[i];
      tick();
    end
    b_in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (i >= qb.size() || qb[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL round_%0d: got %0d (n=%0d) want %0d",
                 i, i < qb.size() ? qb[i] : 8'sd0, qb.size(), exp[i]);
      end
    end
    n_tests++;
    if (b_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL round_sat: got sat=%0b want 0", b_sat);
    end
  endtask

  task automatic test_saturation();
    qb.delete();
    b_out_ready = 1'b1;
    b_in_valid = 1'b1;
    b_in_data = 16'h7FFF;
    tick();
    b_in_valid = 1'b0;
    tick();
    n_tests++;
    if (b_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_set: got sat=%0b want 1", b_sat);
    end
    b_in_valid = 1'b1;
    b_in_data = 16'h8000;
    tick();
    b_in_valid = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (qb.size() != 2 || qb[0] !== 8'sd127 || qb[1] !== -8'sd128) begin
      n_fail++;
      $display("FAIL sat_vals: got n=%0d [%0d,%0d] want n=2 [127,-128]",
               qb.size(), qb.size() > 0 ? qb[0] : 8'sd0,
               qb.size() > 1 ? qb[1] : 8'sd0);
    end
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    n_tests++;
    if (b_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clr: got sat=%0b want 0", b_sat);
    end
    b_clr = 1'b1;
    b_in_valid = 1'b1;
    b_in_data = 16'h7FFF;
    tick();
    b_clr = 1'b0;
    b_in_valid = 1'b0;
    n_tests++;
    if (b_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clr_race: got sat=%0b want 1", b_sat);
    end
    repeat (3) tick();
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    b_out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      b_in_valid = 1'b1;
      b_in_data = 16'(64 * k);
      tick();
    end
    b_in_valid = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (b_level !== 3'd4 || b_ovf !== 1'b1 || b_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: got lvl=%0d ovf=%0b v=%0b want 4,1,1",
               b_level, b_ovf, b_out_valid);
    end
    qb.delete();
    b_out_ready = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= qb.size() || qb[i] !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: got %0d (n=%0d) want %0d",
                 i, i < qb.size() ? qb[i] : 8'sd0, qb.size(), i + 1);
      end
    end
    n_tests++;
    if (qb.size() != 4 || b_out_valid !== 1'b0 || b_level !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_empty: got n=%0d v=%0b lvl=%0d want 4,0,0",
               qb.size(), b_out_valid, b_level);
    end
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    n_tests++;
    if (b_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ovf_clr: got ovf=%0b want 0", b_ovf);
    end
  endtask

  task automatic test_back_to_back();
    qb.delete();
    b_out_ready = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      b_in_valid = 1'b1;
      b_in_data = 16'(64 * k);
      if (k == 6) b_out_ready = 1'b1;
      tick();
      if (k >= 5) begin
        n_tests++;
        if (b_level !== 3'd4) begin
          n_fail++;
          $display("FAIL b2b_level_%0d: got %0d want 4", k, b_level);
        end
      end
    end
    b_in_valid = 1'b0;
    repeat (8) tick();
    n_tests++;
    if (b_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ovf: got ovf=%0b want 0", b_ovf);
    end
    n_tests++;
    if (qb.size() != 11) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 11", qb.size());
    end
    for (int i = 0; i < 11; i++) begin
      n_tests++;
      if (i >= qb.size() || qb[i] !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_seq_%0d: got %0d want %0d",
                 i, i < qb.size() ? qb[i] : 8'sd0, i + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] din [5];
    din = '{16'd64, 16'd0, 16'h7FFF, 16'd0, 16'd192};
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_in_data = din[i];
      tick();
    end
    a_in_valid = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (a_level !== 3'd3 || a_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got lvl=%0d sat=%0b want 3,1", a_level, a_sat);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_level !== 3'd0 ||
        a_sat !== 1'b0 || a_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: got v=%0b lvl=%0d sat=%0b ovf=%0b want 0,0,0,0",
               a_out_valid, a_level, a_sat, a_ovf);
    end
    tick();
    rst = 1'b0;
    tick();
    qa.delete();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    a_in_data = 16'd128;
    tick();
    a_in_valid = 1'b0;
    tick();
    n_tests++;
    if (a_out_valid !== 1'b1 || $signed(a_out_data) !== 8'sd2) begin
      n_fail++;
      $display("FAIL rmid_phase0: got v=%0b d=%0d want 1,2",
               a_out_valid, $signed(a_out_data));
    end
    repeat (2) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_decim();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_out_decim.md
Name: fir_out_decim

Overview:
Output stage placed directly downstream of the 3-tap FIR. It consumes the signed 16-bit FIR output stream and decimates it by DECIM. It rescales each kept sample by 2^-SHIFT with rounding, which removes the 8-bit coefficient gain. It then saturates the result to signed 8 bits and buffers it in a small FIFO behind a valid/ready interface. Sticky flags report saturation and FIFO overflow.

Parameters:
IN_W, 16, input sample width (signed)
OUT_W, 8, output sample width (signed)
SHIFT, 6, arithmetic right-shift applied before saturation; must be >= 1
DECIM, 2, decimation ratio; must be >= 1 (1 = keep every sample)
DEPTH, 4, FIFO depth; must be a power of 2 and >= 2

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  in_data is a new FIR sample this cycle
in_data  in  IN_W  signed FIR output sample
clr_flags  in  1  synchronous clear of sat_flag and ovf_flag
out_valid  out  1  FIFO non-empty; out_data valid
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  OUT_W  signed, rounded, saturated sample (head of FIFO)
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
sat_flag  out  1  sticky: a kept sample saturated
ovf_flag  out  1  sticky: a sample was dropped on a full FIFO

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-high on rst. While rst is high, all of the following are 0: phase counter, pipe_valid, pipe_data, rd/wr pointers, fifo_level, out_valid, sat_flag, ovf_flag. out_data reads 0 during reset. FIFO memory is not cleared.
- Decimation: phase counter runs 0..DECIM-1 and advances only on in_valid, wrapping to 0. A sample is kept when in_valid=1 and phase==0. The first valid sample after reset is therefore always kept. Cycles with in_valid=0 leave phase unchanged.
- Arithmetic, all at IN_W+1 bits signed:
  - t = in_data + 2^(SHIFT-1), then r = t >>> SHIFT (arithmetic shift, floor). This is round-half-up.
  - If r > 2^(OUT_W-1)-1, the result is 127; if r < -2^(OUT_W-1), it is -128; otherwise it is r[OUT_W-1:0].
  - Saturation of a kept sample sets sat_flag.
- Pipeline: kept sample sampled at edge E0. pipe_valid/pipe_data are registered at E0. The FIFO write happens at E1. out_valid rises after E1 if the FIFO was empty. Latency from input edge to out_valid is 2 cycles. Throughput is 1 sample per cycle.
- FIFO:
  - push = pipe_valid; pop = out_valid & out_ready.
  - out_data = mem[rd_ptr] (show-ahead). Its value is don't-care when out_valid=0.
  - Push on a non-full FIFO writes the entry and level+1. Pop decrements level. Push and pop in the same cycle leave level unchanged.
  - Full with push and no pop: the sample is dropped, ovf_flag is set, and level stays DEPTH.
  - Full with push and pop: both occur, nothing is dropped.
  - Empty with pop cannot occur because out_valid=0.
  - Pointers wrap modulo DEPTH. out_valid = (level != 0).
- Flags: sticky until clr_flags or rst. If clr_flags and a new sat/ovf event fall in the same cycle, the event wins and the flag ends at 1.
- Reset mid-operation: in-flight pipe sample and FIFO contents are discarded. The phase restarts at 0 after rst deasserts.
- out_ready may toggle freely. The consumer never sees a duplicated or reordered sample.

Test Plan:
1. DECIM=2, SHIFT=6, out_ready=1, continuous in_valid, in_data=64,128,192,256 -> out_data 1 then 3. out_valid first asserts 2 cycles after the 64 input edge. Samples 128 and 256 are discarded.
2. Rounding, DECIM=1: in_data 31, 32, -32, -33, -96 -> out 0, 1, 0, -1, -1. sat_flag stays 0.
3. Saturation: in_data 16'h7FFF -> 127, and 16'h8000 -> -128 (-32736>>>6 = -512). sat_flag=1 after the first. Pulsing clr_flags clears it. Pulsing clr_flags in the same cycle as a saturating sample leaves sat_flag=1.
4. Backpressure: DECIM=1, out_ready=0, push 6 samples 64..384 step 64 -> fifo_level=4, ovf_flag=1. Raising out_ready then drains 1,2,3,4 in order, after which out_valid=0 and fifo_level=0.
5. Full and simultaneous: fill FIFO to 4, then hold out_ready=1 with continuous input -> level stays 4, ovf_flag stays 0, and the output sequence has no gaps.
6. Reset mid-stream: assert rst asynchronously (mid-cycle) with 3 entries queued and phase=1 -> out_valid=0 and fifo_level=0 immediately, flags are 0. After release, the next valid input is kept (phase 0).
